id_ex_stage: RTL
================

// Module: id_ex_stage
// PURPOSE
//  ID/EX pipeline register plus operand-select/forwarding logic directly upstream of the ALU.
//  Captures decoded instruction fields, resolves RAW hazards from EX/MEM and MEM/WB, and presents
//  o_data_a/o_data_b/o_op in the operand order the ALU expects (shifts: value on A, amount on B).
// PARAMETERS
//  NB_DATA       32  datapath width
//  NB_REG_ADDR    5  register-file address width
//  NB_OPERATION   6  ALU funct code width
//  NB_SHAMT       5  shift-amount field width
// PORTS
//  i_clock            in  1             clock, rising edge
//  i_reset            in  1             asynchronous, active-low reset
//  i_valid            in  1             decode stage presents a valid instruction
//  i_stall            in  1             hold current contents (hazard unit)
//  i_flush            in  1             replace contents with bubble
//  i_rs_data          in  NB_DATA       register-file rs read
//  i_rt_data          in  NB_DATA       register-file rt read
//  i_imm              in  NB_DATA       sign-extended immediate
//  i_shamt            in  NB_SHAMT      instruction shamt field
//  i_op               in  NB_OPERATION  ALU funct code
//  i_rs_addr          in  NB_REG_ADDR   rs index
//  i_rt_addr          in  NB_REG_ADDR   rt index
//  i_rd_addr          in  NB_REG_ADDR   destination index
//  i_alu_src_imm      in  1             B operand = immediate instead of rt
//  i_shift_var        in  1             shift amount from rs[NB_SHAMT-1:0], else shamt
//  i_reg_write        in  1             instruction writes rd
//  i_exmem_reg_write  in  1 / i_exmem_rd in NB_REG_ADDR / i_exmem_result in NB_DATA  EX/MEM bypass
//  i_memwb_reg_write  in  1 / i_memwb_rd in NB_REG_ADDR / i_memwb_result in NB_DATA  MEM/WB bypass
//  o_data_a           out NB_DATA       ALU operand A
//  o_data_b           out NB_DATA       ALU operand B
//  o_op               out NB_OPERATION  ALU operation
//  o_rd_addr          out NB_REG_ADDR   destination index to EX/MEM
//  o_reg_write        out 1             write-enable to EX/MEM (0 when invalid)
//  o_valid            out 1             stage holds a real instruction
// BEHAVIOUR
//  - Reset (i_reset=0, async): all stored fields 0, stored op=ADD (6'b100000), o_valid=0, o_reg_write=0.
//  - Edge priority: flush > stall > load. Flush: valid=0, reg_write=0, op=ADD, data fields unchanged.
//    Stall: all fields held. Load: every field captured; valid=i_valid, reg_write=i_reg_write&i_valid.
//  - Latency: 1 cycle from inputs to outputs; bypass path from i_exmem_*/i_memwb_* to o_data_* is combinational.
//  - Forward select per source (rs, rt) on stored address s: if exmem_reg_write & exmem_rd==s & s!=0 -> exmem_result;
//    elif memwb_reg_write & memwb_rd==s & s!=0 -> memwb_result; else stored data. EX/MEM always wins.
//  - Stall refresh: while stalled, a MEM/WB write matching a stored non-zero rs/rt overwrites that stored data.
//  - Operand mapping: op in {SRA 6'b000011, SRL 6'b000010}: A=fwd(rt);
//    B=i_shift_var ? zero-ext fwd(rs)[NB_SHAMT-1:0] : zero-ext shamt. Otherwise A=fwd(rs);
//    B=i_alu_src_imm ? imm : fwd(rt).
//  - Register $0 is never forwarded; stored $0 data passes through unchanged.
//  - Reset asserted mid-stall or mid-flush: reset wins immediately; no partial state retained.
// CONFIGURATION
//  ID_EX_FORWARD_EN defined: forwarding and stall refresh as above.
//  Undefined: o_data_* use stored register data only; all i_exmem_*/i_memwb_* ports ignored (kept for pin compatibility).
// STRUCTURE
//  mips_pkg: ALU funct localparams (ADD, SUB, AND, OR, XOR, SRA, SRL, NOR) and NB_* defaults, shared with ALU and decoder.
//  Sub-module fwd_mux: one forwarding selector (address compare + 3:1 mux), instantiated for rs and rt.
// TESTING
//  1 Reset: hold i_reset=0 with random inputs -> o_valid=0, o_reg_write=0, o_op=6'b100000, o_data_a=o_data_b=0.
//  2 ADD rs=$1(5) rt=$2(7), no bypass -> next cycle o_data_a=5, o_data_b=7, o_op=ADD, o_valid=1.
//  3 Bypass priority: stored rs=$3; exmem_rd=3 result=0xAA and memwb_rd=3 result=0xBB, both writes -> o_data_a=0xAA;
//    drop exmem write -> 0xBB; rs=$0 with exmem_rd=0 -> stored value.
//  4 SRA rt=$4(0xF0000000), shamt=4, i_shift_var=0 -> o_data_a=0xF0000000, o_data_b=4; i_shift_var=1, rs=36 -> o_data_b=4.
//  5 Stall 3 cycles with memwb_rd=rt write 0x55 in cycle 2, then release -> o_data_b=0x55 after memwb deasserts; flush+stall
//    same edge -> o_valid=0, o_reg_write=0.
//  6 Macro undefined: repeat test 3 -> o_data_a equals stored rs data regardless of bypass inputs.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared MIPS datapath widths and ALU funct codes used by the decoder, ID/EX stage and ALU.
// id_ex_stage forwarding is built only when ID_EX_FORWARD_EN is defined.
package mips_pkg;

    localparam int unsigned DEF_NB_DATA      = 32;
    localparam int unsigned DEF_NB_REG_ADDR  = 5;
    localparam int unsigned DEF_NB_OPERATION = 6;
    localparam int unsigned DEF_NB_SHAMT     = 5;

    localparam logic [5:0] ALU_ADD = 6'b100000;
    localparam logic [5:0] ALU_SUB = 6'b100010;
    localparam logic [5:0] ALU_AND = 6'b100100;
    localparam logic [5:0] ALU_OR  = 6'b100101;
    localparam logic [5:0] ALU_XOR = 6'b100110;
    localparam logic [5:0] ALU_NOR = 6'b100111;
    localparam logic [5:0] ALU_SRA = 6'b000011;
    localparam logic [5:0] ALU_SRL = 6'b000010;

    typedef enum logic [1:0] {
        FWD_REG   = 2'd0,
        FWD_EXMEM = 2'd1,
        FWD_MEMWB = 2'd2
    } fwd_sel_e;

    function automatic logic is_shift(input logic [5:0] op);
        return (op == ALU_SRA) || (op == ALU_SRL);
    endfunction

endpackage

// File: rtl/id_ex_stage_if.sv
// Decode-side inputs, EX/MEM and MEM/WB bypass inputs and ALU-side outputs of the ID/EX stage.
// Bypass signals stay present even when ID_EX_FORWARD_EN is undefined, for pin compatibility.
interface id_ex_stage_if
    import mips_pkg::*;
#(
    parameter int unsigned NB_DATA      = DEF_NB_DATA,
    parameter int unsigned NB_REG_ADDR  = DEF_NB_REG_ADDR,
    parameter int unsigned NB_OPERATION = DEF_NB_OPERATION,
    parameter int unsigned NB_SHAMT     = DEF_NB_SHAMT
) ();

    logic                    i_valid;
    logic                    i_stall;
    logic                    i_flush;
    logic [NB_DATA-1:0]      i_rs_data;
    logic [NB_DATA-1:0]      i_rt_data;
    logic [NB_DATA-1:0]      i_imm;
    logic [NB_SHAMT-1:0]     i_shamt;
    logic [NB_OPERATION-1:0] i_op;
    logic [NB_REG_ADDR-1:0]  i_rs_addr;
    logic [NB_REG_ADDR-1:0]  i_rt_addr;
    logic [NB_REG_ADDR-1:0]  i_rd_addr;
    logic                    i_alu_src_imm;
    logic                    i_shift_var;
    logic                    i_reg_write;

    logic                    i_exmem_reg_write;
    logic [NB_REG_ADDR-1:0]  i_exmem_rd;
    logic [NB_DATA-1:0]      i_exmem_result;
    logic                    i_memwb_reg_write;
    logic [NB_REG_ADDR-1:0]  i_memwb_rd;
    logic [NB_DATA-1:0]      i_memwb_result;

    logic [NB_DATA-1:0]      o_data_a;
    logic [NB_DATA-1:0]      o_data_b;
    logic [NB_OPERATION-1:0] o_op;
    logic [NB_REG_ADDR-1:0]  o_rd_addr;
    logic                    o_reg_write;
    logic                    o_valid;

    modport master (
        output i_valid, i_stall, i_flush, i_rs_data, i_rt_data, i_imm, i_shamt, i_op,
               i_rs_addr, i_rt_addr, i_rd_addr, i_alu_src_imm, i_shift_var, i_reg_write,
               i_exmem_reg_write, i_exmem_rd, i_exmem_result,
               i_memwb_reg_write, i_memwb_rd, i_memwb_result,
        input  o_data_a, o_data_b, o_op, o_rd_addr, o_reg_write, o_valid
    );

    modport slave (
        input  i_valid, i_stall, i_flush, i_rs_data, i_rt_data, i_imm, i_shamt, i_op,
               i_rs_addr, i_rt_addr, i_rd_addr, i_alu_src_imm, i_shift_var, i_reg_write,
               i_exmem_reg_write, i_exmem_rd, i_exmem_result,
               i_memwb_reg_write, i_memwb_rd, i_memwb_result,
        output o_data_a, o_data_b, o_op, o_rd_addr, o_reg_write, o_valid
    );

endinterface

// File: rtl/id_ex_stage_fwd_mux.sv
// One forwarding selector: picks EX/MEM, then MEM/WB, then the stored register value.
// Register $0 is never forwarded.
module fwd_mux
    import mips_pkg::*;
#(
    parameter int unsigned NB_DATA     = DEF_NB_DATA,
    parameter int unsigned NB_REG_ADDR = DEF_NB_REG_ADDR
) (
    input  logic [NB_REG_ADDR-1:0] i_addr,
    input  logic [NB_DATA-1:0]     i_data,
    input  logic                   i_exmem_reg_write,
    input  logic [NB_REG_ADDR-1:0] i_exmem_rd,
    input  logic [NB_DATA-1:0]     i_exmem_result,
    input  logic                   i_memwb_reg_write,
    input  logic [NB_REG_ADDR-1:0] i_memwb_rd,
    input  logic [NB_DATA-1:0]     i_memwb_result,
    output logic [NB_DATA-1:0]     o_data
);

    fwd_sel_e sel;

    always_comb begin
        sel = FWD_REG;
        if (i_addr != '0) begin
            if (i_exmem_reg_write && (i_exmem_rd == i_addr)) begin
                sel = FWD_EXMEM;
            end else if (i_memwb_reg_write && (i_memwb_rd == i_addr)) begin
                sel = FWD_MEMWB;
            end
        end
    end

    always_comb begin
        o_data = i_data;
        case (sel)
            FWD_EXMEM: o_data = i_exmem_result;
            FWD_MEMWB: o_data = i_memwb_result;
            default:   o_data = i_data;
        endcase
    end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with operand selection for the ALU (shifts: value on A, amount on B).
// Define ID_EX_FORWARD_EN to enable EX/MEM and MEM/WB bypassing and MEM/WB refresh during stall.
module id_ex_stage
    import mips_pkg::*;
#(
    parameter int unsigned NB_DATA      = DEF_NB_DATA,
    parameter int unsigned NB_REG_ADDR  = DEF_NB_REG_ADDR,
    parameter int unsigned NB_OPERATION = DEF_NB_OPERATION,
    parameter int unsigned NB_SHAMT     = DEF_NB_SHAMT
) (
    input  logic          i_clock,
    input  logic          i_reset,
    id_ex_stage_if.slave  bus
);

    localparam logic [NB_OPERATION-1:0] OP_ADD = NB_OPERATION'(ALU_ADD);

    logic [NB_DATA-1:0]      rs_data_q;
    logic [NB_DATA-1:0]      rt_data_q;
    logic [NB_DATA-1:0]      imm_q;
    logic [NB_SHAMT-1:0]     shamt_q;
    logic [NB_OPERATION-1:0] op_q;
    logic [NB_REG_ADDR-1:0]  rs_addr_q;
    logic [NB_REG_ADDR-1:0]  rt_addr_q;
    logic [NB_REG_ADDR-1:0]  rd_addr_q;
    logic                    alu_src_imm_q;
    logic                    shift_var_q;
    logic                    reg_write_q;
    logic                    valid_q;

    logic                    refresh_rs;
    logic                    refresh_rt;
    logic [NB_DATA-1:0]      fwd_rs;
    logic [NB_DATA-1:0]      fwd_rt;
    logic                    shift_op;

`ifdef ID_EX_FORWARD_EN
    // A MEM/WB write retires while we stall; capture it so it is not lost once it leaves the bypass.
    assign refresh_rs = bus.i_memwb_reg_write && (rs_addr_q != '0) && (bus.i_memwb_rd == rs_addr_q);
    assign refresh_rt = bus.i_memwb_reg_write && (rt_addr_q != '0) && (bus.i_memwb_rd == rt_addr_q);

    fwd_mux #(
        .NB_DATA     (NB_DATA),
        .NB_REG_ADDR (NB_REG_ADDR)
    ) u_fwd_rs (
        .i_addr            (rs_addr_q),
        .i_data            (rs_data_q),
        .i_exmem_reg_write (bus.i_exmem_reg_write),
        .i_exmem_rd        (bus.i_exmem_rd),
        .i_exmem_result    (bus.i_exmem_result),
        .i_memwb_reg_write (bus.i_memwb_reg_write),
        .i_memwb_rd        (bus.i_memwb_rd),
        .i_memwb_result    (bus.i_memwb_result),
        .o_data            (fwd_rs)
    );

    fwd_mux #(
        .NB_DATA     (NB_DATA),
        .NB_REG_ADDR (NB_REG_ADDR)
    ) u_fwd_rt (
        .i_addr            (rt_addr_q),
        .i_data            (rt_data_q),
        .i_exmem_reg_write (bus.i_exmem_reg_write),
        .i_exmem_rd        (bus.i_exmem_rd),
        .i_exmem_result    (bus.i_exmem_result),
        .i_memwb_reg_write (bus.i_memwb_reg_write),
        .i_memwb_rd        (bus.i_memwb_rd),
        .i_memwb_result    (bus.i_memwb_result),
        .o_data            (fwd_rt)
    );
`else
    logic unused_bypass;

    assign refresh_rs    = 1'b0;
    assign refresh_rt    = 1'b0;
    assign fwd_rs        = rs_data_q;
    assign fwd_rt        = rt_data_q;
    assign unused_bypass = ^{bus.i_exmem_reg_write, bus.i_exmem_rd, bus.i_exmem_result,
                             bus.i_memwb_reg_write, bus.i_memwb_rd, bus.i_memwb_result};
`endif

    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            rs_data_q     <= '0;
            rt_data_q     <= '0;
            imm_q         <= '0;
            shamt_q       <= '0;
            op_q          <= OP_ADD;
            rs_addr_q     <= '0;
            rt_addr_q     <= '0;
            rd_addr_q     <= '0;
            alu_src_imm_q <= 1'b0;
            shift_var_q   <= 1'b0;
            reg_write_q   <= 1'b0;
            valid_q       <= 1'b0;
        end else if (bus.i_flush) begin
            valid_q     <= 1'b0;
            reg_write_q <= 1'b0;
            op_q        <= OP_ADD;
        end else if (bus.i_stall) begin
            if (refresh_rs) rs_data_q <= bus.i_memwb_result;
            if (refresh_rt) rt_data_q <= bus.i_memwb_result;
        end else begin
            rs_data_q     <= bus.i_rs_data;
            rt_data_q     <= bus.i_rt_data;
            imm_q         <= bus.i_imm;
            shamt_q       <= bus.i_shamt;
            op_q          <= bus.i_op;
            rs_addr_q     <= bus.i_rs_addr;
            rt_addr_q     <= bus.i_rt_addr;
            rd_addr_q     <= bus.i_rd_addr;
            alu_src_imm_q <= bus.i_alu_src_imm;
            shift_var_q   <= bus.i_shift_var;
            reg_write_q   <= bus.i_reg_write & bus.i_valid;
            valid_q       <= bus.i_valid;
        end
    end

    assign shift_op = (op_q == NB_OPERATION'(ALU_SRA)) || (op_q == NB_OPERATION'(ALU_SRL));

    always_comb begin
        bus.o_data_a = fwd_rs;
        bus.o_data_b = alu_src_imm_q ? imm_q : fwd_rt;
        if (shift_op) begin
            bus.o_data_a = fwd_rt;
            bus.o_data_b = shift_var_q ? NB_DATA'(fwd_rs[NB_SHAMT-1:0]) : NB_DATA'(shamt_q);
        end
    end

    assign bus.o_op        = op_q;
    assign bus.o_rd_addr   = rd_addr_q;
    assign bus.o_reg_write = reg_write_q;
    assign bus.o_valid     = valid_q;

endmodule
